// File: rtl/wl_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : wl_sensor_conditioner
// Brief   : Synchronizes, debounces and validates the three tank float
//           switches; latches a fault and forces "full" on persistent
//           inconsistency.
// Revision: 1.0 - initial release
// ============================================================================
module wl_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_s1,
    input  logic       raw_s2,
    input  logic       raw_s3,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic [1:0] level,
    output logic       level_chg,
    output logic       fault
);

    localparam int c_deb_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_flt_w = $clog2(FAULT_CYCLES + 1);
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_flt_w-1:0] c_flt_last = c_flt_w'(FAULT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_VALID   = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    logic [2:0]         w_raw;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         w_deb;
    logic               w_valid;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_flt_w-1:0] r_fcnt;
    logic [c_flt_w-1:0] w_fcnt_nxt;
    logic [2:0]         r_s;
    logic [2:0]         w_s_nxt;
    logic [1:0]         r_level;
    logic [1:0]         w_level_nxt;
    logic               r_level_chg;
    logic               r_fault;
    logic               w_fault_nxt;

    assign w_raw = {raw_s3, raw_s2, raw_s1};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic               r_stable;
            logic [c_deb_w-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stable <= 1'b0;
                    r_cnt    <= '0;
                end else if (r_sync2[gi] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_last) begin
                    r_stable <= r_sync2[gi];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb[gi] = r_stable;
        end
    endgenerate

    // Float switches fill bottom-up, so only thermometer patterns are legal.
    assign w_valid = (w_deb == 3'b000) || (w_deb == 3'b001) ||
                     (w_deb == 3'b011) || (w_deb == 3'b111);

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_s_nxt     = r_s;
        w_fault_nxt = r_fault;
        case (r_state)
            ST_VALID: begin
                if (w_valid) begin
                    w_s_nxt = w_deb;
                end else if (FAULT_CYCLES == 1) begin
                    w_state_nxt = ST_FAULT;
                    w_s_nxt     = 3'b111;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_SUSPECT;
                    w_fcnt_nxt  = c_flt_w'(1);
                end
            end
            ST_SUSPECT: begin
                if (w_valid) begin
                    w_state_nxt = ST_VALID;
                    w_fcnt_nxt  = '0;
                    w_s_nxt     = w_deb;
                end else if (r_fcnt == c_flt_last) begin
                    w_state_nxt = ST_FAULT;
                    w_s_nxt     = 3'b111;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_fcnt_nxt = r_fcnt + 1'b1;
                end
            end
            ST_FAULT: begin
                w_s_nxt     = 3'b111;
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_VALID;
                w_fcnt_nxt  = '0;
            end
        endcase
    end

    assign w_level_nxt = {1'b0, w_s_nxt[0]} + {1'b0, w_s_nxt[1]} + {1'b0, w_s_nxt[2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_VALID;
            r_fcnt      <= '0;
            r_s         <= '0;
            r_level     <= '0;
            r_level_chg <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_s         <= w_s_nxt;
            r_level     <= w_level_nxt;
            r_level_chg <= (w_s_nxt != r_s);
            r_fault     <= w_fault_nxt;
        end
    end

    assign s1        = r_s[0];
    assign s2        = r_s[1];
    assign s3        = r_s[2];
    assign level     = r_level;
    assign level_chg = r_level_chg;
    assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_wl_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_wl_sensor_conditioner
// Brief   : Vector table plus scoreboard bench for wl_sensor_conditioner.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wl_sensor_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] raw;
    logic       s1, s2, s3;
    logic [1:0] level;
    logic       level_chg;
    logic       fault;

    wl_sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .FAULT_CYCLES   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_s1   (raw[0]),
        .raw_s2   (raw[1]),
        .raw_s3   (raw[2]),
        .s1       (s1),
        .s2       (s2),
        .s3       (s3),
        .level    (level),
        .level_chg(level_chg),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] raw;
        int         hold;
        int         lat;
        logic [2:0] s;
        logic       f;
    } vec_t;

    typedef struct {
        int         due;
        logic [2:0] s;
        logic       f;
        logic       rst;
    } exp_t;

    localparam int NV = 19;
    vec_t tbl [NV];
    exp_t sbq [$];

    int         cyc = 0;
    int         n_checks = 0;
    int         n_err = 0;
    logic       chk_en = 1'b0;
    logic       done = 1'b0;
    logic       final_done = 1'b0;
    logic [2:0] cur_s = 3'b000;
    logic       cur_f = 1'b0;

    function automatic logic [1:0] pc3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic exp_chg;
        exp_t e;
        exp_chg = 1'b0;
        if (chk_en && !final_done) begin
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                if (!e.rst && e.s != cur_s) exp_chg = 1'b1;
                cur_s = e.s;
                cur_f = e.f;
            end
            n_checks++;
            if ({s3, s2, s1} !== cur_s || level !== pc3(cur_s) ||
                fault !== cur_f || level_chg !== exp_chg) begin
                n_err++;
                $display("FAIL outputs @cycle %0d: got s=%b level=%0d chg=%b fault=%b, expected s=%b level=%0d chg=%b fault=%b",
                         cyc, {s3, s2, s1}, level, level_chg, fault,
                         cur_s, pc3(cur_s), exp_chg, cur_f);
            end
            if (done) begin
                n_checks++;
                if (sbq.size() != 0) begin
                    n_err++;
                    $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
                end
                final_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int lat, input logic [2:0] s, input logic f, input logic rst);
        exp_t e;
        e.due = cyc + lat;
        e.s   = s;
        e.f   = f;
        e.rst = rst;
        sbq.push_back(e);
    endtask

    initial begin
        //          rst   raw     hold lat  s       f
        tbl[0]  = '{1'b1, 3'b000, 3,   1,  3'b000, 1'b0};
        tbl[1]  = '{1'b0, 3'b000, 10,  0,  3'b000, 1'b0};
        tbl[2]  = '{1'b0, 3'b001, 20,  7,  3'b001, 1'b0};
        tbl[3]  = '{1'b0, 3'b011, 3,   0,  3'b000, 1'b0};
        tbl[4]  = '{1'b0, 3'b001, 20,  0,  3'b000, 1'b0};
        tbl[5]  = '{1'b0, 3'b011, 20,  7,  3'b011, 1'b0};
        tbl[6]  = '{1'b0, 3'b111, 20,  7,  3'b111, 1'b0};
        tbl[7]  = '{1'b0, 3'b011, 20,  7,  3'b011, 1'b0};
        tbl[8]  = '{1'b0, 3'b001, 20,  7,  3'b001, 1'b0};
        tbl[9]  = '{1'b0, 3'b101, 5,   0,  3'b000, 1'b0};
        tbl[10] = '{1'b0, 3'b011, 20,  7,  3'b011, 1'b0};
        tbl[11] = '{1'b0, 3'b000, 20,  7,  3'b000, 1'b0};
        tbl[12] = '{1'b0, 3'b001, 4,   7,  3'b001, 1'b0};
        tbl[13] = '{1'b0, 3'b000, 20,  7,  3'b000, 1'b0};
        tbl[14] = '{1'b0, 3'b010, 30,  14, 3'b111, 1'b1};
        tbl[15] = '{1'b0, 3'b000, 15,  0,  3'b000, 1'b0};
        tbl[16] = '{1'b1, 3'b111, 2,   1,  3'b000, 1'b0};
        tbl[17] = '{1'b0, 3'b000, 10,  0,  3'b000, 1'b0};
        tbl[18] = '{1'b0, 3'b000, 5,   0,  3'b000, 1'b0};

        reset = 1'b1;
        raw   = 3'b000;
        @(negedge clk);
        #1;
        chk_en = 1'b1;

        for (int i = 0; i < NV; i++) begin
            reset = tbl[i].rst;
            raw   = tbl[i].raw;
            if (tbl[i].lat > 0) push(tbl[i].lat, tbl[i].s, tbl[i].f, tbl[i].rst);
            repeat (tbl[i].hold) tick();
        end

        // Reset landing mid-debounce must restart the full latency from release.
        raw = 3'b001;
        repeat (3) tick();
        reset = 1'b1;
        push(1, 3'b000, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        push(7, 3'b001, 1'b0, 1'b0);
        repeat (15) tick();

        // A 3-cycle glitch on the top sensor must not move anything.
        raw = 3'b101;
        repeat (3) tick();
        raw = 3'b001;
        repeat (12) tick();

        done = 1'b1;
        repeat (3) tick();
        if (!final_done) begin
            n_checks++;
            n_err++;
            $display("FAIL end_of_test: got checker not drained, expected drained");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
